// File: rtl/sos_morse_generator.sv
// sos_morse_generator
// Plays one Morse "SOS" pattern (. . . - - - . . .) on Pin_Out for each
// start pulse on SOS_En_Sig. Busy_Sig is high while a pattern plays and
// Done_Sig pulses for one cycle when it completes. All outputs are registered.
//
// Build option: define SOS_TONE_EN to make Pin_Out toggle every T_TONE cycles
// during a mark, for a passive buzzer. Without it, Pin_Out is a steady 1
// during a mark, for an LED or an active buzzer.
module sos_morse_generator #(
    parameter int T_UNIT = 5_000_000,  // cycles per Morse time unit, minimum 2
    parameter int T_TONE = 12_500      // tone half-period in cycles (tone build only)
) (
    input  logic CLK,
    input  logic RST,
    input  logic SOS_En_Sig,
    output logic Pin_Out,
    output logic Busy_Sig,
    output logic Done_Sig
);

    localparam int CYC_W = (T_UNIT > 1) ? $clog2(T_UNIT) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_UNIT - 1);
    localparam logic [3:0] IDX_LAST = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       idx_reg, idx_next;
    logic [CYC_W-1:0] cyc_reg, cyc_next;
    logic [1:0]       unit_reg, unit_next;
    logic             pin_reg, pin_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Decoded element properties: dashes are indices 3..5, letter gaps follow 2 and 5
    logic       is_dash;
    logic       is_letter_gap;
    logic [1:0] mark_last_unit;
    logic [1:0] gap_last_unit;
    logic       unit_done;
    logic       mark_done;
    logic       gap_done;

    // Element decode and end-of-element detection
    always_comb begin
        is_dash        = (idx_reg >= 4'd3) && (idx_reg <= 4'd5);
        is_letter_gap  = (idx_reg == 4'd2) || (idx_reg == 4'd5);
        mark_last_unit = is_dash ? 2'd2 : 2'd0;
        gap_last_unit  = is_letter_gap ? 2'd2 : 2'd0;
        unit_done      = (cyc_reg == CYC_LAST);
        mark_done      = unit_done && (unit_reg == mark_last_unit);
        gap_done       = unit_done && (unit_reg == gap_last_unit);
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        // Counters free-run within an element; cleared below on every state change
        if (unit_done) begin
            cyc_next  = '0;
            unit_next = unit_reg + 2'd1;
        end else begin
            cyc_next  = cyc_reg + CYC_W'(1);
            unit_next = unit_reg;
        end

        case (state_reg)
            IDLE: begin
                cyc_next  = '0;
                unit_next = 2'd0;
                if (SOS_En_Sig) begin
                    state_next = MARK;
                    idx_next   = 4'd0;
                end
            end
            MARK: begin
                if (mark_done) begin
                    cyc_next  = '0;
                    unit_next = 2'd0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SPACE;
                    end
                end
            end
            SPACE: begin
                if (gap_done) begin
                    cyc_next   = '0;
                    unit_next  = 2'd0;
                    idx_next   = idx_reg + 4'd1;
                    state_next = MARK;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
                cyc_next   = '0;
                unit_next  = 2'd0;
            end
        endcase

        // Outputs are computed from the next state so they line up with it
        busy_next = (state_next != IDLE);
    end

`ifdef SOS_TONE_EN
    localparam int TONE_W = (T_TONE > 1) ? $clog2(T_TONE) : 1;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(T_TONE - 1);

    logic [TONE_W-1:0] tone_reg, tone_next;

    // Tone generator: restarts high at each mark, toggles every T_TONE cycles
    always_comb begin
        tone_next = '0;
        pin_next  = 1'b0;
        if (state_next == MARK) begin
            if (state_reg != MARK) begin
                tone_next = '0;
                pin_next  = 1'b1;
            end else if (tone_reg == TONE_LAST) begin
                tone_next = '0;
                pin_next  = ~pin_reg;
            end else begin
                tone_next = tone_reg + TONE_W'(1);
                pin_next  = pin_reg;
            end
        end
    end

    // Tone counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            tone_reg <= '0;
        end else begin
            tone_reg <= tone_next;
        end
    end
`else
    // Steady output during a mark; the tone half-period has no effect here
    always_comb begin
        pin_next = (state_next == MARK);
    end

    if (T_TONE < 1) begin : g_tone_param_range
    end
`endif

    // State, counters and output registers; reset abandons any pattern silently
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            cyc_reg   <= '0;
            unit_reg  <= 2'd0;
            pin_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cyc_reg   <= cyc_next;
            unit_reg  <= unit_next;
            pin_reg   <= pin_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign Pin_Out  = pin_reg;
    assign Busy_Sig = busy_reg;
    assign Done_Sig = done_reg;

endmodule

// File: doc/sos_morse_generator.md
# sos_morse_generator

Plays one Morse "SOS" pattern (· · · — — — · · ·) on a single output pin each time it receives a one-cycle start pulse. It consumes the periodic enable pulse produced by the SOS enable timer upstream and drives the board LED or buzzer pin. It is also reusable on its own with any pulse source.

## Interface
- `T_UNIT`, default 5_000_000: cycles per Morse time unit (100 ms at 50 MHz); minimum 2.
- `T_TONE`, default 12_500: half-period of the buzzer tone in cycles (2 kHz at 50 MHz); used only with `SOS_TONE_EN`.
- `CLK` (input, 1): system clock; every register updates on its rising edge.
- `RST` (input, 1): synchronous, active-high reset.
- `SOS_En_Sig` (input, 1): start pulse; sampled on every clock edge.
- `Pin_Out` (output, 1): Morse output; 1 during a mark, 0 during a space or idle.
- `Busy_Sig` (output, 1): 1 while a pattern is playing.
- `Done_Sig` (output, 1): one-cycle pulse when a pattern completes.

## Operation
- **States:** IDLE, MARK, SPACE.
- **Elements:** indices 0..8.
  - Indices 0–2 and 6–8 are dots, lasting 1 unit.
  - Indices 3–5 are dashes, lasting 3 units.
- **Gap after each element:**
  - 3 units after index 2 and after index 5 (letter gap).
  - 1 unit after every other element.
  - No gap after index 8.
- **Pattern length:** 27 units in total, i.e. 27·`T_UNIT` cycles.
- **IDLE:** when `SOS_En_Sig`=1, load element index 0, clear the counters and go to MARK. When `SOS_En_Sig`=0, stay in IDLE.
- **MARK:** count the mark length.
  - At the end of the mark, go to SPACE if index < 8.
  - If index = 8, go to IDLE and pulse `Done_Sig`.
- **SPACE:** count the gap length. At the end of the gap, increment the index and go to MARK.
- **Counters:**
  - Cycle counter runs 0..`T_UNIT`-1 and is sized to `$clog2(T_UNIT)`.
  - Unit counter runs 0..2 and is 2 bits wide.
  - Both counters clear on every state change.
- **`SOS_En_Sig` while MARK or SPACE:** ignored. It does not restart or queue a pattern.
- **`SOS_En_Sig` in the cycle `Done_Sig`=1:** the block is already in IDLE, so the pulse is accepted and a new pattern starts.
- **Held-high `SOS_En_Sig`:** patterns play back-to-back. Each new pattern starts in the cycle after `Done_Sig`.
- **`RST`=1:** takes effect at the next edge regardless of state.
  - State becomes IDLE; index and both counters clear.
  - `Pin_Out`, `Busy_Sig` and `Done_Sig` become 0.
  - An in-progress pattern is abandoned with no `Done_Sig`.
  - Reset has priority over `SOS_En_Sig`.

## Timing
- Reset values: `Pin_Out`=0, `Busy_Sig`=0, `Done_Sig`=0. All outputs are registered.
- Start latency: if `SOS_En_Sig` is sampled high at edge k, `Pin_Out` and `Busy_Sig` are 1 from edge k+1.
- Mark lengths on `Pin_Out` are exactly `T_UNIT` cycles (dot) or 3·`T_UNIT` cycles (dash).
- Space lengths are exactly `T_UNIT` or 3·`T_UNIT` cycles.
- `Busy_Sig` is high for exactly 27·`T_UNIT` cycles.
- `Done_Sig` is high for one cycle, the first cycle in which `Busy_Sig`=0. `Pin_Out` is 0 in that cycle.
- With the defaults, one pattern takes 2.7 s. This fits within a 3 s enable period, so no enable pulse is lost.

## Configuration
- **`SOS_TONE_EN` defined:**
  - During MARK, `Pin_Out` toggles every `T_TONE` cycles, starting at 1 on the first mark cycle. This drives a passive buzzer.
  - The tone counter resets at the start of every mark.
  - During SPACE and IDLE, `Pin_Out`=0.
- **`SOS_TONE_EN` not defined:**
  - `Pin_Out` is a steady 1 during MARK, for an LED or active buzzer.
  - The tone counter and `T_TONE` logic are absent.
- `Busy_Sig` and `Done_Sig` timing is identical in both builds.

## Test plan
All scenarios use `T_UNIT`=4; the tone scenario also uses `T_TONE`=2.
- **Reset:** `RST`=1 for 3 cycles. → All outputs are 0 during and after reset, and stay 0 with no `SOS_En_Sig`.
- **Basic pattern:** one-cycle `SOS_En_Sig` at cycle 10.
  - `Busy_Sig` is high for cycles 11–118.
  - `Pin_Out` high runs, in cycles: 4, 4, 4, 12, 12, 12, 4, 4, 4.
  - Gaps between runs, in cycles: 4, 4, 12, 4, 4, 12, 4, 4.
  - `Done_Sig` is high in cycle 119 only.
- **Ignored retrigger:** a second `SOS_En_Sig` at cycle 50, mid-pattern. → Waveform is identical to the basic pattern, and exactly one `Done_Sig` occurs.
- **Back-to-back:** `SOS_En_Sig` held high continuously. → `Done_Sig` occurs every 109 cycles, and `Pin_Out` goes high in the cycle after each `Done_Sig`.
- **Reset mid-pattern:** `RST` pulsed at cycle 60 during the O dashes.
  - All outputs are 0 from cycle 61, and no `Done_Sig` occurs.
  - A later `SOS_En_Sig` plays a full, correct pattern.
- **Tone build (`SOS_TONE_EN` defined, `T_TONE`=2):** each 4-cycle dot on `Pin_Out` reads 1,1,0,0, and spaces read 0.
